msrv32_pc_gen: RTL and testbench
================================

// Module: msrv32_pc_gen
// PURPOSE
//  Program-counter stage downstream of msrv32_bu: consumes branch_taken_out and selects the next fetch address.
//  Candidate sources: sequential PC+4, branch/jump target from the immediate adder, trap vector and mret return address.
//  Holds the fetch address and the PC of the instruction in execute as registers.
//  Stalls on instruction-bus wait states without losing a redirect, and flags wrong-path fetches and misaligned targets.
// PARAMETERS
//  BOOT_ADDR  32'h0000_0000  first fetch address after reset; must be word-aligned
// PORTS
//  ms_riscv32_mp_clk_in   in   1   core clock, all state on rising edge
//  ms_riscv32_mp_rst_in   in   1   asynchronous, active-high reset
//  branch_taken_in        in   1   from msrv32_bu: jump, or branch with condition true
//  iaddr_in               in   32  branch/jump target from immediate adder (rs1+imm or pc+imm)
//  trap_taken_in          in   1   trap/interrupt accepted this cycle
//  trap_address_in        in   32  trap vector (mtvec-derived)
//  mret_in                in   1   mret in execute
//  epc_in                 in   32  mepc return address
//  ahb_ready_in           in   1   instruction bus ready; 0 = wait state, stall
//  i_addr_out             out  32  fetch address presented to instruction memory (registered)
//  pc_out                 out  32  PC of instruction in execute (registered)
//  pc_plus_4_out          out  32  pc_out+4, link value for JAL/JALR (combinational)
//  misaligned_instr_out   out  1   branch_taken_in & target bit[1]=1 (combinational)
//  flush_out              out  1   instruction returning this cycle is wrong-path/invalid; decode must bubble it
// BEHAVIOUR
//  Reset (async assert): i_addr_out=BOOT_ADDR, pc_out=BOOT_ADDR, flush_out=1, pend_v=0, state=BOOT.
//  FSM: BOOT -> RUN on first edge with ahb_ready_in=1 after reset release.
//   - BOOT: flush_out=1, i_addr_out=BOOT_ADDR, no redirect is accepted.
//   - RUN: normal operation; returns to BOOT only through reset. Reset mid-stall or mid-redirect discards all state.
//  Target for branches: tgt = {iaddr_in[31:1],1'b0}. misaligned = branch_taken_in & tgt[1].
//  Redirect priority (highest first): trap_taken_in -> trap_address_in; mret_in -> epc_in;
//   branch_taken_in & !misaligned -> tgt; pend_v -> pend_addr; else sequential i_addr_out+4.
//  Misaligned branch: no redirect from the branch (sequential path is used); the trap unit follows with trap_taken_in.
//  Edge with ahb_ready_in=1 (RUN):
//   - pc_out <= i_addr_out; i_addr_out <= selected next address.
//   - flush_out <= 1 if a redirect (trap/mret/branch/pending) was taken, else 0.
//   - pend_v <= 0.
//  Edge with ahb_ready_in=0 (stall): i_addr_out, pc_out and flush_out hold.
//   - Any trap/mret/valid-branch redirect is captured into pend_addr and pend_v<=1.
//   - A later, higher-or-equal priority redirect in the same stall overwrites pend_addr (last-highest wins).
//  Single pending slot; it is consumed on the first ready edge unless a live redirect overrides it
//   (the live one wins; pend_v still clears).
//  Adds are modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 and no flag is raised.
//  Latency: redirect seen in cycle N -> i_addr_out=target after edge N (one ready edge); flush_out high for exactly
//   the one returning cycle following the redirect.
//  Simultaneous trap_taken_in & branch_taken_in: trap wins and the branch is dropped (not pended).
//  flush_out is never 0 while state=BOOT.
// TESTING
//  1 Reset release, ready=1, BOOT_ADDR=0x100 -> i_addr_out 0x100,0x104,0x108...; pc_out lags one cycle;
//    flush_out=1 only in the BOOT cycle.
//  2 pc_out=0x200, i_addr_out=0x204, branch_taken_in=1, iaddr_in=0x301 -> next i_addr_out=0x300, pc_out=0x204,
//    flush_out=1 for one cycle, then 0x304.
//  3 branch_taken_in=1, iaddr_in=0x402 -> misaligned_instr_out=1 same cycle, i_addr_out advances +4 only;
//    trap_taken_in next cycle with trap_address_in=0x80 -> i_addr_out=0x80.
//  4 ahb_ready_in=0 for 3 cycles, branch to 0x500 pulsed in cycle 1 -> outputs hold; on ready,
//    i_addr_out=0x500, flush_out=1.
//  5 trap_taken_in, mret_in and branch_taken_in all high (trap 0x80, epc 0x90, tgt 0xA0) -> i_addr_out=0x80.
//  6 i_addr_out=0xFFFF_FFFC, ready=1, no redirect -> i_addr_out=0x0; async reset mid-stall ->
//    immediate BOOT_ADDR and pend_v=0.

Source files
------------

// File: rtl/msrv32_pc_gen.sv
// Program-counter stage of the msrv32 core.
// Chooses the next fetch address from trap vector, mret return address,
// branch/jump target, a single pending redirect slot, or sequential PC+4.
// Redirects that arrive during instruction-bus wait states are remembered in
// the pending slot and applied on the next ready edge. flush_out marks the
// instruction returning from the bus as wrong-path so decode can bubble it.
module msrv32_pc_gen #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        ahb_ready_in,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        misaligned_instr_out,
    output logic        flush_out
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Redirect priority levels; larger value wins. 0 means "no redirect".
    localparam logic [1:0] PRIO_NONE   = 2'd0;
    localparam logic [1:0] PRIO_BRANCH = 2'd1;
    localparam logic [1:0] PRIO_MRET   = 2'd2;
    localparam logic [1:0] PRIO_TRAP   = 2'd3;

    state_t      state_reg;
    logic [31:0] i_addr_reg;
    logic [31:0] pc_reg;
    logic        flush_reg;
    logic        pend_v_reg;
    logic [31:0] pend_addr_reg;
    logic [1:0]  pend_prio_reg;

    logic [31:0] branch_tgt;
    logic        branch_ok;
    logic        live_v;
    logic [31:0] live_addr;
    logic [1:0]  live_prio;
    logic [31:0] seq_addr;
    logic [31:0] next_addr;
    logic        redirect;
    logic        pend_capture;

    // Branch target with bit 0 cleared; bit 1 set means a misaligned target,
    // which is not followed here (the trap unit raises the exception instead).
    assign branch_tgt           = {iaddr_in[31:1], 1'b0};
    assign misaligned_instr_out = branch_taken_in & branch_tgt[1];
    assign branch_ok            = branch_taken_in & ~branch_tgt[1];

    // Highest-priority live redirect this cycle; lower ones are dropped.
    always_comb begin
        live_v    = 1'b0;
        live_addr = 32'h0;
        live_prio = PRIO_NONE;
        if (trap_taken_in) begin
            live_v    = 1'b1;
            live_addr = trap_address_in;
            live_prio = PRIO_TRAP;
        end else if (mret_in) begin
            live_v    = 1'b1;
            live_addr = epc_in;
            live_prio = PRIO_MRET;
        end else if (branch_ok) begin
            live_v    = 1'b1;
            live_addr = branch_tgt;
            live_prio = PRIO_BRANCH;
        end
    end

    // Next fetch address on a ready edge: live redirect beats the pending one.
    always_comb begin
        seq_addr  = i_addr_reg + 32'd4;
        next_addr = seq_addr;
        redirect  = 1'b0;
        if (live_v) begin
            next_addr = live_addr;
            redirect  = 1'b1;
        end else if (pend_v_reg) begin
            next_addr = pend_addr_reg;
            redirect  = 1'b1;
        end
    end

    // During a stall a redirect replaces the pending one only when it is of
    // equal or higher priority, so the last of the highest-priority requests wins.
    assign pend_capture = live_v & (~pend_v_reg | (live_prio >= pend_prio_reg));

    // Boot/run state machine with fetch/execute PC, flush and pending-slot registers.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_reg     <= BOOT;
            i_addr_reg    <= BOOT_ADDR;
            pc_reg        <= BOOT_ADDR;
            flush_reg     <= 1'b1;
            pend_v_reg    <= 1'b0;
            pend_addr_reg <= 32'h0;
            pend_prio_reg <= PRIO_NONE;
        end else begin
            case (state_reg)
                BOOT: begin
                    // No redirect is honoured until the first fetch is accepted.
                    if (ahb_ready_in) begin
                        state_reg  <= RUN;
                        pc_reg     <= i_addr_reg;
                        i_addr_reg <= seq_addr;
                        flush_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    if (ahb_ready_in) begin
                        pc_reg        <= i_addr_reg;
                        i_addr_reg    <= next_addr;
                        flush_reg     <= redirect;
                        pend_v_reg    <= 1'b0;
                        pend_prio_reg <= PRIO_NONE;
                    end else if (pend_capture) begin
                        pend_v_reg    <= 1'b1;
                        pend_addr_reg <= live_addr;
                        pend_prio_reg <= live_prio;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                    flush_reg <= 1'b1;
                end
            endcase
        end
    end

    assign i_addr_out    = i_addr_reg;
    assign pc_out        = pc_reg;
    assign pc_plus_4_out = pc_reg + 32'd4;
    assign flush_out     = flush_reg;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Testbench for msrv32_pc_gen: directed vector table, a reset-mid-stall
// sequence, then random stimulus against a request-list reference model.
module tb_msrv32_pc_gen;

    localparam logic [31:0] BOOT = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [31:0] ia;
    logic        trap;
    logic [31:0] ta;
    logic        mret;
    logic [31:0] epc;
    logic        rdy;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    msrv32_pc_gen #(.BOOT_ADDR(BOOT)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .branch_taken_in      (br),
        .iaddr_in             (ia),
        .trap_taken_in        (trap),
        .trap_address_in      (ta),
        .mret_in              (mret),
        .epc_in               (epc),
        .ahb_ready_in         (rdy),
        .i_addr_out           (i_addr),
        .pc_out               (pc),
        .pc_plus_4_out        (pc4),
        .misaligned_instr_out (mis),
        .flush_out            (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] ia;
        logic        trap;
        logic [31:0] ta;
        logic        mret;
        logic [31:0] epc;
        logic [31:0] e_iaddr;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    typedef struct {
        int          prio;
        logic [31:0] addr;
    } req_t;

    typedef req_t req_q_t[$];

    vec_t tbl[31];

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] a,
                                input logic t, input logic [31:0] tad,
                                input logic m, input logic [31:0] e,
                                input logic [31:0] xi, input logic [31:0] xp,
                                input logic xf, input logic xm);
        vec_t v;
        v.rdy = r; v.br = b; v.ia = a; v.trap = t; v.ta = tad; v.mret = m; v.epc = e;
        v.e_iaddr = xi; v.e_pc = xp; v.e_flush = xf; v.e_mis = xm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] a,
                         input logic t, input logic [31:0] tad,
                         input logic m, input logic [31:0] e);
        rdy = r; br = b; ia = a; trap = t; ta = tad; mret = m; epc = e;
    endtask

    task automatic chk_regs(input string nm, input logic [31:0] xi,
                            input logic [31:0] xp, input logic xf);
        chk({nm, ".i_addr"}, i_addr, xi);
        chk({nm, ".pc"}, pc, xp);
        chk({nm, ".pc_plus_4"}, pc4, xp + 32'd4);
        chk({nm, ".flush"}, {31'd0, flush}, {31'd0, xf});
    endtask

    // Reference model: pick the highest-priority request, latest among equals.
    function automatic req_t pick(input req_q_t q);
        req_t best;
        best.prio = 0;
        best.addr = 32'h0;
        foreach (q[k]) if (q[k].prio >= best.prio) best = q[k];
        return best;
    endfunction

    bit          m_boot;
    logic [31:0] m_fetch;
    logic [31:0] m_exec;
    logic        m_flush;
    req_q_t      m_pend;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Directed table (BOOT_ADDR = 0x100)
        tbl[0]  = mk(1,0,0,0,0,0,0,                       32'h104, 32'h100, 0, 0);
        tbl[1]  = mk(1,0,0,0,0,0,0,                       32'h108, 32'h104, 0, 0);
        tbl[2]  = mk(1,1,32'h200,0,0,0,0,                 32'h200, 32'h108, 1, 0);
        tbl[3]  = mk(1,0,0,0,0,0,0,                       32'h204, 32'h200, 0, 0);
        tbl[4]  = mk(1,1,32'h301,0,0,0,0,                 32'h300, 32'h204, 1, 0);
        tbl[5]  = mk(1,0,0,0,0,0,0,                       32'h304, 32'h300, 0, 0);
        tbl[6]  = mk(1,1,32'h402,0,0,0,0,                 32'h308, 32'h304, 0, 1);
        tbl[7]  = mk(1,0,0,1,32'h80,0,0,                  32'h080, 32'h308, 1, 0);
        tbl[8]  = mk(1,0,0,0,0,0,0,                       32'h084, 32'h080, 0, 0);
        tbl[9]  = mk(0,1,32'h500,0,0,0,0,                 32'h084, 32'h080, 0, 0);
        tbl[10] = mk(0,0,0,0,0,0,0,                       32'h084, 32'h080, 0, 0);
        tbl[11] = mk(0,0,0,0,0,0,0,                       32'h084, 32'h080, 0, 0);
        tbl[12] = mk(1,0,0,0,0,0,0,                       32'h500, 32'h084, 1, 0);
        tbl[13] = mk(1,0,0,0,0,0,0,                       32'h504, 32'h500, 0, 0);
        tbl[14] = mk(0,0,0,1,32'hC0,0,0,                  32'h504, 32'h500, 0, 0);
        tbl[15] = mk(0,1,32'h600,0,0,0,0,                 32'h504, 32'h500, 0, 0);
        tbl[16] = mk(0,0,0,0,0,1,32'hD0,                  32'h504, 32'h500, 0, 0);
        tbl[17] = mk(0,0,0,1,32'hE0,0,0,                  32'h504, 32'h500, 0, 0);
        tbl[18] = mk(1,0,0,0,0,0,0,                       32'h0E0, 32'h504, 1, 0);
        tbl[19] = mk(1,0,0,0,0,0,0,                       32'h0E4, 32'h0E0, 0, 0);
        tbl[20] = mk(0,1,32'h700,0,0,0,0,                 32'h0E4, 32'h0E0, 0, 0);
        tbl[21] = mk(1,0,0,0,0,1,32'h90,                  32'h090, 32'h0E4, 1, 0);
        tbl[22] = mk(1,0,0,0,0,0,0,                       32'h094, 32'h090, 0, 0);
        tbl[23] = mk(1,1,32'hA0,1,32'h80,1,32'h90,        32'h080, 32'h094, 1, 0);
        tbl[24] = mk(1,0,0,0,0,1,32'h200,                 32'h200, 32'h080, 1, 0);
        tbl[25] = mk(1,0,0,0,0,0,0,                       32'h204, 32'h200, 0, 0);
        tbl[26] = mk(0,1,32'h602,0,0,0,0,                 32'h204, 32'h200, 0, 1);
        tbl[27] = mk(1,0,0,0,0,0,0,                       32'h208, 32'h204, 0, 0);
        tbl[28] = mk(1,0,0,1,32'hFFFF_FFFC,0,0,           32'hFFFF_FFFC, 32'h208, 1, 0);
        tbl[29] = mk(1,0,0,0,0,0,0,                       32'h0, 32'hFFFF_FFFC, 0, 0);
        tbl[30] = mk(1,0,0,0,0,0,0,                       32'h4, 32'h0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset", BOOT, BOOT, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_regs("boot_stall", BOOT, BOOT, 1'b1);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            drive(tbl[i].rdy, tbl[i].br, tbl[i].ia, tbl[i].trap, tbl[i].ta, tbl[i].mret, tbl[i].epc);
            #1;
            chk($sformatf("vec%0d.misaligned", i), {31'd0, mis}, {31'd0, tbl[i].e_mis});
            @(posedge clk);
            #1;
            chk_regs($sformatf("vec%0d", i), tbl[i].e_iaddr, tbl[i].e_pc, tbl[i].e_flush);
            $display("vec %0d: i_addr=%h pc=%h flush=%0b mis=%0b", i, i_addr, pc, flush, mis);
        end

        // Reset asserted mid-stall with a redirect pending
        @(negedge clk);
        drive(0, 1, 32'h900, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_regs("async_rst", BOOT, BOOT, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_regs("boot_no_redirect", BOOT, BOOT, 1'b1);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_regs("post_rst_run0", BOOT + 32'd4, BOOT, 1'b0);
        @(posedge clk);
        #1;
        chk_regs("post_rst_run1", BOOT + 32'd8, BOOT + 32'd4, 1'b0);
        $display("reset-mid-stall sequence: i_addr=%h pc=%h flush=%0b", i_addr, pc, flush);

        // Random phase against the reference model
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        m_boot = 1'b1; m_fetch = BOOT; m_exec = BOOT; m_flush = 1'b1;
        m_pend.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            req_q_t live;
            req_t   r;
            logic   e_mis;
            @(negedge clk);
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
            e_mis = br & ia[1];
            live.delete();
            if (trap) begin r.prio = 3; r.addr = ta; live.push_back(r); end
            if (mret) begin r.prio = 2; r.addr = epc; live.push_back(r); end
            if (br && !ia[1]) begin r.prio = 1; r.addr = {ia[31:1], 1'b0}; live.push_back(r); end
            if (rdy) begin
                m_exec = m_fetch;
                if (m_boot) begin
                    m_fetch = m_fetch + 32'd4;
                    m_flush = 1'b0;
                    m_boot  = 1'b0;
                end else if (live.size() > 0) begin
                    m_fetch = pick(live).addr;
                    m_flush = 1'b1;
                end else if (m_pend.size() > 0) begin
                    m_fetch = pick(m_pend).addr;
                    m_flush = 1'b1;
                end else begin
                    m_fetch = m_fetch + 32'd4;
                    m_flush = 1'b0;
                end
                m_pend.delete();
            end else if (!m_boot) begin
                foreach (live[k]) m_pend.push_back(live[k]);
            end
            #1;
            chk($sformatf("rnd%0d.misaligned", c), {31'd0, mis}, {31'd0, e_mis});
            @(posedge clk);
            #1;
            chk_regs($sformatf("rnd%0d", c), m_fetch, m_exec, m_flush);
        end
        $display("random phase: 3000 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
